xilinx_reset_sequencer: RTL and testbench
=========================================

// Module: xilinx_reset_sequencer
// PURPOSE
//  Downstream consumer of the synchronised reset from xilinx_reset_sync; orders reset release across dependent domains.
//  Holds all stage resets asserted until the MMCM/PLL lock input has been stable for a filter window.
//  Then releases the stage resets one at a time, stage 0 first, with a fixed spacing between releases.
//  Any lock loss or soft reset re-asserts every stage reset and restarts the sequence.
// PARAMETERS
//  STAGES       4   number of sequenced reset outputs, 1..16
//  LOCK_FILTER  8   consecutive synced-high lock samples required before sequencing, >=1
//  HOLD_CYCLES  16  clk cycles between successive stage releases (and before stage 0), >=1
// PORTS
//  clk         in   1       single clock; all logic in this domain
//  rst_n       in   1       asynchronous active-low reset (driven by synchronised reset_sync output)
//  lock        in   1       MMCM/PLL locked, asynchronous; 2-FF synchronised internally (ASYNC_REG)
//  soft_rst    in   1       synchronous active-high restart request
//  rst_stage   out  STAGES  active-high resets; bit k released after bit k-1
//  seq_done    out  1       high when all stages released
//  relock_cnt  out  8       saturating count of lock losses after sequencing began
// BEHAVIOUR
//  Reset (rst_n=0, async):
//  - state=S_WAIT_LOCK; rst_stage all 1; seq_done=0; relock_cnt=0.
//  - Counters and index cleared; lock sync FFs=0.
//  lock_s = lock through 2 FFs; all decisions use lock_s only.
//  FSM (registered outputs, all updates on clk rising edge):
//  - S_WAIT_LOCK: cnt++ while lock_s=1, cnt=0 when lock_s=0.
//    After LOCK_FILTER consecutive high samples -> S_SEQ, cnt=0, idx=0.
//  - S_SEQ: cnt++ each cycle. When cnt==HOLD_CYCLES-1: clear rst_stage[idx], cnt=0, idx++.
//    If idx==STAGES-1 -> S_DONE and seq_done=1 on that same edge.
//  - S_DONE: hold outputs; seq_done=1.
//  Abort (lock_s=0 in S_SEQ/S_DONE, or soft_rst=1 in any state), next edge:
//  - rst_stage all 1; seq_done=0; cnt=0; idx=0; -> S_WAIT_LOCK.
//  - relock_cnt+1 (saturate at 255) only for lock_s loss in S_SEQ/S_DONE.
//  - soft_rst never counts; soft_rst and lock loss together count once.
//  soft_rst held high keeps FSM in S_WAIT_LOCK with cnt=0.
//  Timing (lock driven high just after edge 0, held):
//  - lock_s=1 at edge 2; S_SEQ entered at edge 2+LOCK_FILTER.
//  - rst_stage[k] falls at edge 2+LOCK_FILTER+HOLD_CYCLES*(k+1); seq_done rises with last stage.
//  Lock dropped just after edge T: lock_s=0 at T+2; outputs re-asserted at edge T+3.
//  Lock glitch shorter than one clk in S_WAIT_LOCK may be missed; if sampled low, filter restarts from 0.
//  rst_stage bits never deassert out of order; a released bit re-asserts only via abort or rst_n.
//  Counter widths: $clog2 of max(LOCK_FILTER,HOLD_CYCLES)+1; idx $clog2(STAGES)+1 bits.
// TESTING
//  T1 defaults, lock high after edge 0 -> rst_stage[0..3] fall at edges 26,42,58,74; seq_done=1 at 74.
//  T2 lock pulses low for 1 clk at edge 6 -> filter restarts; rst_stage[0] falls 6 edges later than T1.
//  T3 lock drops after edge 50 (stage0,1 released) -> all rst_stage=1, seq_done=0 at edge 53; relock_cnt=1.
//  T4 soft_rst=1 for 1 clk in S_DONE -> rst_stage=4'hF next edge; relock_cnt unchanged; re-sequence from filter.
//  T5 rst_n low mid-S_SEQ, async (between edges) -> rst_stage=4'hF, relock_cnt=0 immediately, without clk.
//  T6 300 lock losses from S_DONE -> relock_cnt saturates at 255, no wrap.

Source files
------------

// File: rtl/xilinx_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// xilinx_reset_sequencer_if
//   Groups the lock/restart inputs and the sequenced reset outputs of the
//   reset sequencer into a single bundle.
//
//   Signals
//     lock        MMCM/PLL locked, asynchronous to clk
//     soft_rst    synchronous active-high restart request
//     rst_stage   active-high stage resets, bit k released after bit k-1
//     seq_done    high once every stage has been released
//     relock_cnt  saturating count of lock losses after sequencing began
//
//   Modports
//     master  drives lock/soft_rst, observes the reset outputs
//     slave   the sequencer itself
// -----------------------------------------------------------------------------
interface xilinx_reset_sequencer_if #(
  parameter int STAGES = 4
);
  logic              lock;
  logic              soft_rst;
  logic [STAGES-1:0] rst_stage;
  logic              seq_done;
  logic [7:0]        relock_cnt;

  modport master (
    output lock,
    output soft_rst,
    input  rst_stage,
    input  seq_done,
    input  relock_cnt
  );

  modport slave (
    input  lock,
    input  soft_rst,
    output rst_stage,
    output seq_done,
    output relock_cnt
  );
endinterface

// File: rtl/xilinx_reset_sequencer.sv
// -----------------------------------------------------------------------------
// xilinx_reset_sequencer
//   Orders reset release across dependent clock domains. All stage resets are
//   held asserted until the (2-FF synchronised) MMCM/PLL lock has been high
//   for LOCK_FILTER consecutive samples. Stages are then released one at a
//   time, stage 0 first, HOLD_CYCLES apart (stage 0 also waits HOLD_CYCLES).
//   A lock loss while sequencing/done, or a soft restart in any state,
//   re-asserts every stage reset and restarts from the lock filter.
//
//   Ports
//     clk    in  single clock, all logic in this domain
//     rst_n  in  asynchronous active-low reset (from the reset synchroniser)
//     bus    slave modport: lock, soft_rst in; rst_stage, seq_done,
//            relock_cnt out (all outputs registered)
// -----------------------------------------------------------------------------
module xilinx_reset_sequencer #(
  parameter int STAGES      = 4,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  xilinx_reset_sequencer_if.slave   bus
);

  localparam int MAX_CNT = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(STAGES) + 1;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_SEQ       = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [STAGES-1:0] rst_stage_q;
  logic              seq_done_q;
  logic [7:0]        relock_cnt_q;

  (* ASYNC_REG = "TRUE" *) logic lock_meta_q;
  (* ASYNC_REG = "TRUE" *) logic lock_sync_q;

  logic              lock_s;
  logic              lock_lost_s;
  logic              abort_s;
  logic              filter_done_s;
  logic              hold_done_s;
  logic              last_stage_s;
  logic [STAGES-1:0] release_mask_s;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= bus.lock;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Decode abort conditions, counter terminal values and the stage to release.
  always_comb begin
    lock_s         = lock_sync_q;
    // Only a loss after sequencing has begun counts as a relock event.
    lock_lost_s    = !lock_s && ((state_q == S_SEQ) || (state_q == S_DONE));
    abort_s        = bus.soft_rst || lock_lost_s;
    filter_done_s  = (cnt_q == CNT_W'(LOCK_FILTER - 1));
    hold_done_s    = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
    last_stage_s   = (idx_q == IDX_W'(STAGES - 1));
    release_mask_s = {STAGES{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      release_mask_s[k] = (idx_q == IDX_W'(k));
    end
  end

  // Sequencing FSM with registered outputs and the relock event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_LOCK;
      cnt_q        <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      rst_stage_q  <= {STAGES{1'b1}};
      seq_done_q   <= 1'b0;
      relock_cnt_q <= 8'd0;
    end else begin
      // A simultaneous soft restart and lock loss still counts exactly once.
      if (lock_lost_s && (relock_cnt_q != 8'hFF)) begin
        relock_cnt_q <= relock_cnt_q + 8'd1;
      end else begin
        relock_cnt_q <= relock_cnt_q;
      end

      if (abort_s) begin
        state_q     <= S_WAIT_LOCK;
        cnt_q       <= {CNT_W{1'b0}};
        idx_q       <= {IDX_W{1'b0}};
        rst_stage_q <= {STAGES{1'b1}};
        seq_done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_WAIT_LOCK: begin
            if (lock_s) begin
              if (filter_done_s) begin
                state_q <= S_SEQ;
                cnt_q   <= {CNT_W{1'b0}};
                idx_q   <= {IDX_W{1'b0}};
              end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
              end
            end else begin
              // Any low sample restarts the filter window.
              cnt_q <= {CNT_W{1'b0}};
            end
          end

          S_SEQ: begin
            if (hold_done_s) begin
              // idx only ever increments, so bits clear strictly in order.
              rst_stage_q <= rst_stage_q & ~release_mask_s;
              cnt_q       <= {CNT_W{1'b0}};
              idx_q       <= idx_q + IDX_W'(1);
              if (last_stage_s) begin
                state_q    <= S_DONE;
                seq_done_q <= 1'b1;
              end else begin
                state_q    <= S_SEQ;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          S_DONE: begin
            seq_done_q <= 1'b1;
          end

          default: begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= {CNT_W{1'b0}};
            idx_q       <= {IDX_W{1'b0}};
            rst_stage_q <= {STAGES{1'b1}};
            seq_done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rst_stage  = rst_stage_q;
  assign bus.seq_done   = seq_done_q;
  assign bus.relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_xilinx_reset_sequencer.sv
module tb_xilinx_reset_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cur_edge;

  xilinx_reset_sequencer_if #(.STAGES(4)) bus_if ();

  xilinx_reset_sequencer #(
    .STAGES      (4),
    .LOCK_FILTER (8),
    .HOLD_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after edge number e (edge 0 = first edge out of reset).
  task automatic step_to(input int e);
    while (cur_edge < e) begin
      @(posedge clk);
      cur_edge++;
    end
    #1;
  endtask

  task automatic start_run;
    rst_n          = 1'b0;
    bus_if.lock     = 1'b0;
    bus_if.soft_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cur_edge = 0;
    #1;
  endtask

  task automatic test_reset;
    rst_n          = 1'b0;
    bus_if.lock     = 1'b1;
    bus_if.soft_rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus_if.rst_stage !== 4'hF) begin
      failures++;
      $display("FAIL reset_rst_stage got=%h exp=%h", bus_if.rst_stage, 4'hF);
    end
    checks++;
    if (bus_if.seq_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_seq_done got=%b exp=0", bus_if.seq_done);
    end
    checks++;
    if (bus_if.relock_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_relock_cnt got=%0d exp=0", bus_if.relock_cnt);
    end
  endtask

  task automatic test_sequence;
    int         e_tab [9] = '{10, 25, 26, 41, 42, 57, 58, 73, 74};
    logic [3:0] r_tab [9] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0};
    logic       d_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_run();
    bus_if.lock = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step_to(e_tab[i]);
      checks++;
      if (bus_if.rst_stage !== r_tab[i] || bus_if.seq_done !== d_tab[i]) begin
        failures++;
        $display("FAIL seq_edge%0d got=%h/%b exp=%h/%b", e_tab[i],
                 bus_if.rst_stage, bus_if.seq_done, r_tab[i], d_tab[i]);
      end
    end
  endtask

  task automatic test_lock_glitch;
    start_run();
    bus_if.lock = 1'b1;
    step_to(5);
    bus_if.lock = 1'b0;
    step_to(6);
    bus_if.lock = 1'b1;
    step_to(26);
    checks++;
    if (bus_if.rst_stage !== 4'hF) begin
      failures++;
      $display("FAIL glitch_edge26 got=%h exp=%h", bus_if.rst_stage, 4'hF);
    end
    step_to(31);
    checks++;
    if (bus_if.rst_stage !== 4'hF) begin
      failures++;
      $display("FAIL glitch_edge31 got=%h exp=%h", bus_if.rst_stage, 4'hF);
    end
    step_to(32);
    checks++;
    if (bus_if.rst_stage !== 4'hE) begin
      failures++;
      $display("FAIL glitch_edge32 got=%h exp=%h", bus_if.rst_stage, 4'hE);
    end
  endtask

  task automatic test_lock_loss;
    start_run();
    bus_if.lock = 1'b1;
    step_to(50);
    checks++;
    if (bus_if.rst_stage !== 4'hC) begin
      failures++;
      $display("FAIL loss_edge50 got=%h exp=%h", bus_if.rst_stage, 4'hC);
    end
    bus_if.lock = 1'b0;
    step_to(52);
    checks++;
    if (bus_if.rst_stage !== 4'hC || bus_if.relock_cnt !== 8'd0) begin
      failures++;
      $display("FAIL loss_edge52 got=%h/%0d exp=%h/0", bus_if.rst_stage, bus_if.relock_cnt, 4'hC);
    end
    step_to(53);
    checks++;
    if (bus_if.rst_stage !== 4'hF || bus_if.seq_done !== 1'b0 || bus_if.relock_cnt !== 8'd1) begin
      failures++;
      $display("FAIL loss_edge53 got=%h/%b/%0d exp=%h/0/1", bus_if.rst_stage,
               bus_if.seq_done, bus_if.relock_cnt, 4'hF);
    end
    bus_if.lock = 1'b1;
    step_to(78);
    checks++;
    if (bus_if.rst_stage !== 4'hF) begin
      failures++;
      $display("FAIL relock_edge78 got=%h exp=%h", bus_if.rst_stage, 4'hF);
    end
    step_to(79);
    checks++;
    if (bus_if.rst_stage !== 4'hE) begin
      failures++;
      $display("FAIL relock_edge79 got=%h exp=%h", bus_if.rst_stage, 4'hE);
    end
  endtask

  // Continues from test_lock_loss: sequence restarted at edge 63.
  task automatic test_soft_reset;
    step_to(127);
    checks++;
    if (bus_if.rst_stage !== 4'h0 || bus_if.seq_done !== 1'b1) begin
      failures++;
      $display("FAIL soft_pre_done got=%h/%b exp=0/1", bus_if.rst_stage, bus_if.seq_done);
    end
    step_to(130);
    bus_if.soft_rst = 1'b1;
    step_to(131);
    bus_if.soft_rst = 1'b0;
    checks++;
    if (bus_if.rst_stage !== 4'hF || bus_if.seq_done !== 1'b0 || bus_if.relock_cnt !== 8'd1) begin
      failures++;
      $display("FAIL soft_abort got=%h/%b/%0d exp=%h/0/1", bus_if.rst_stage,
               bus_if.seq_done, bus_if.relock_cnt, 4'hF);
    end
    step_to(154);
    checks++;
    if (bus_if.rst_stage !== 4'hF) begin
      failures++;
      $display("FAIL soft_reseq_edge154 got=%h exp=%h", bus_if.rst_stage, 4'hF);
    end
    step_to(155);
    checks++;
    if (bus_if.rst_stage !== 4'hE) begin
      failures++;
      $display("FAIL soft_reseq_edge155 got=%h exp=%h", bus_if.rst_stage, 4'hE);
    end
  endtask

  // Continues from test_soft_reset: mid S_SEQ with relock_cnt=1.
  task automatic test_async_reset;
    step_to(160);
    checks++;
    if (bus_if.rst_stage !== 4'hE || bus_if.relock_cnt !== 8'd1) begin
      failures++;
      $display("FAIL async_pre got=%h/%0d exp=%h/1", bus_if.rst_stage, bus_if.relock_cnt, 4'hE);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.rst_stage !== 4'hF || bus_if.relock_cnt !== 8'd0 || bus_if.seq_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%0d exp=%h/0/0", bus_if.rst_stage,
               bus_if.seq_done, bus_if.relock_cnt, 4'hF);
    end
  endtask

  task automatic test_soft_and_loss;
    start_run();
    bus_if.lock = 1'b1;
    step_to(80);
    checks++;
    if (bus_if.seq_done !== 1'b1) begin
      failures++;
      $display("FAIL combo_done got=%b exp=1", bus_if.seq_done);
    end
    bus_if.lock = 1'b0;
    step_to(82);
    bus_if.soft_rst = 1'b1;
    step_to(83);
    bus_if.soft_rst = 1'b0;
    checks++;
    if (bus_if.rst_stage !== 4'hF || bus_if.relock_cnt !== 8'd1) begin
      failures++;
      $display("FAIL combo_abort got=%h/%0d exp=%h/1", bus_if.rst_stage, bus_if.relock_cnt, 4'hF);
    end
    step_to(84);
    checks++;
    if (bus_if.relock_cnt !== 8'd1) begin
      failures++;
      $display("FAIL combo_count_once got=%0d exp=1", bus_if.relock_cnt);
    end
  endtask

  // Continues from test_soft_and_loss: soft_rst held keeps the filter at 0.
  task automatic test_soft_hold;
    bus_if.lock     = 1'b1;
    bus_if.soft_rst = 1'b1;
    step_to(120);
    bus_if.soft_rst = 1'b0;
    checks++;
    if (bus_if.rst_stage !== 4'hF || bus_if.seq_done !== 1'b0 || bus_if.relock_cnt !== 8'd1) begin
      failures++;
      $display("FAIL hold_soft got=%h/%b/%0d exp=%h/0/1", bus_if.rst_stage,
               bus_if.seq_done, bus_if.relock_cnt, 4'hF);
    end
    step_to(143);
    checks++;
    if (bus_if.rst_stage !== 4'hF) begin
      failures++;
      $display("FAIL hold_edge143 got=%h exp=%h", bus_if.rst_stage, 4'hF);
    end
    step_to(144);
    checks++;
    if (bus_if.rst_stage !== 4'hE) begin
      failures++;
      $display("FAIL hold_edge144 got=%h exp=%h", bus_if.rst_stage, 4'hE);
    end
  endtask

  task automatic test_saturation;
    int         n;
    logic [7:0] exp_cnt;
    start_run();
    for (int i = 0; i < 300; i++) begin
      bus_if.lock = 1'b1;
      n = 0;
      while (bus_if.seq_done !== 1'b1 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      checks++;
      if (bus_if.seq_done !== 1'b1) begin
        failures++;
        $display("FAIL sat_seq_done iter=%0d got=%b exp=1", i, bus_if.seq_done);
      end
      bus_if.lock = 1'b0;
      n = 0;
      while (bus_if.rst_stage !== 4'hF && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      exp_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
      checks++;
      if (bus_if.rst_stage !== 4'hF || bus_if.relock_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL sat_count iter=%0d got=%h/%0d exp=%h/%0d", i,
                 bus_if.rst_stage, bus_if.relock_cnt, 4'hF, exp_cnt);
      end
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    cur_edge        = 0;
    rst_n           = 1'b0;
    bus_if.lock     = 1'b0;
    bus_if.soft_rst = 1'b0;
    test_reset();
    test_sequence();
    test_lock_glitch();
    test_lock_loss();
    test_soft_reset();
    test_async_reset();
    test_soft_and_loss();
    test_soft_hold();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
